ghr_checkpoint_ctrl: RTL
========================

# ghr_checkpoint_ctrl

Speculative global-history controller for the front-end branch predictor. Shifts predicted directions into a speculative global history register at fetch, checkpoints the pre-shift history per in-flight conditional branch, and restores the corrected history on a mispredict. Produces the PHT index (history XOR PC). It sits between fetch, the PHT, and the execute/commit stages.

## Interface
- G_WIDTH, 7: MSB index of the history, PC slice and index; all three are G_WIDTH+1 bits wide.
- DEPTH, 4: checkpoint entries, i.e. the maximum number of in-flight branches. Must be a power of 2, ≥2.
- PTR_W, $clog2(DEPTH): tag and pointer width.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- PC  in  G_WIDTH+1  low PC bits of the fetch-stage instruction.
- predict  in  1  fetch holds a conditional branch this cycle.
- predTaken  in  1  predicted direction for that branch (1 = taken).
- index  out  G_WIDTH+1  PHT index = specHistory ^ PC; combinational.
- tagOut  out  PTR_W  checkpoint tag for the fetch branch; equals tail.
- stall  out  1  a predict in this cycle is not accepted; fetch must hold.
- resolve  in  1  execute resolved the branch named by resolveTag.
- resolveTag  in  PTR_W  tag of the resolving branch.
- mispredict  in  1  qualifies resolve: the prediction was wrong.
- actualTaken  in  1  resolved direction.
- commit  in  1  the oldest in-flight branch retires.
- count  out  PTR_W+1  number of occupied checkpoints.

## Operation
- State:
  - specHistory[G_WIDTH:0]
  - ckpt[DEPTH], each G_WIDTH+1 bits
  - head and tail, each PTR_W bits
  - count
  - FSM {NORMAL, RECOVER}
- Reset values: specHistory, head, tail and count are 0; state is NORMAL. As a result stall=0, tagOut=0, count=0, and index=PC.
- stall = (count==DEPTH) | (state==RECOVER).
- Accepted predict = predict & ~stall & ~(resolve & mispredict & tag valid). On accept:
  - ckpt[tail] <= specHistory (the pre-shift value).
  - specHistory <= {specHistory[G_WIDTH-1:0], predTaken}.
  - tail <= tail+1 (wraps mod DEPTH); count +1.
- Tag valid: ((resolveTag - head) mod DEPTH) < count.
- Valid mispredict (resolve & mispredict & tag valid), with t = resolveTag:
  - specHistory <= {ckpt[t][G_WIDTH-1:0], actualTaken}.
  - tail <= t+1; all younger branches are discarded.
  - count <= ((t - head) mod DEPTH) + 1 - commit.
  - state <= RECOVER.
- Mispredict has priority over a same-cycle predict; that predict is dropped and fetch refetches.
- Correct resolve (resolve & ~mispredict) changes no state.
- Resolve with an invalid tag is ignored entirely.
- commit & count!=0: head <= head+1; count -1.
  - Combined with an accepted predict, count is unchanged and head and tail both advance.
  - Commit with count==0 is ignored.
- A same-cycle commit plus mispredict on the head tag is legal: count becomes 0 and head = tail = t+1.
- FSM transitions:
  - NORMAL → RECOVER on a valid mispredict.
  - RECOVER → NORMAL unconditionally after one cycle.
  - A valid mispredict in RECOVER re-enters RECOVER and applies its restore. It is valid only if the tag is older than the surviving tail.
- History arithmetic is a pure shift: MSB discarded, new outcome enters at LSB. Pointers and tags wrap modulo DEPTH.

## Timing
- index and tagOut: zero latency from PC and state.
- Accepted predict: the new specHistory is visible in index on the next cycle.
- Mispredict at edge N:
  - Restored history visible after N.
  - stall=1 for exactly the cycle after N.
  - predict accepted again from cycle N+2.
- Full: stall rises the cycle after the DEPTH-th accept. It falls the cycle after a commit frees an entry. A commit in the same cycle as a full-stall does not unblock that cycle's predict.
- reset asserted at any point, including mid-RECOVER: all state and outputs return to reset values without a clock edge. First accept is possible on the first posedge after deassertion.

## Test plan
- Reset, PC=0x00, then predicts T, T, N on consecutive cycles:
  - index = 0x00, 0x01, 0x03 in those cycles, then 0x06.
  - tagOut = 0, 1, 2.
  - count = 3.
- DEPTH=4, 4 taken predicts:
  - count=4 and stall=1.
  - A fifth predict leaves specHistory at 0x0F.
  - A commit gives count=3, and stall=0 on the next cycle.
- From 0x00, predicts T, T, T (tags 0–2; history 0x07), then mispredict tag1 with actualTaken=0:
  - specHistory = 0x02, tail=2, count=2.
  - stall=1 for one cycle; the predict asserted with the mispredict is dropped.
- count=2, head=0, ckpt0=0x00: mispredict tag0 with actualTaken=1, plus commit, in the same cycle:
  - count=0, head = tail = 1, specHistory = 0x01.
- Assert reset asynchronously mid-RECOVER with history 0x5A:
  - Before the next edge, index=PC, count=0, stall=0.
- Commit with count=0, and resolve+mispredict with a stale tag (tag 3 when head=0, count=2):
  - No change to history, pointers, count or state.

Source files
------------

// File: rtl/ghr_checkpoint_ctrl.sv
// ghr_checkpoint_ctrl
//   Speculative global-history controller for the front-end branch predictor.
//   At fetch, each accepted conditional-branch prediction is shifted into the
//   speculative history. The pre-shift history is checkpointed in a circular
//   buffer slot named by the branch's tag. On a mispredict, the history is
//   rebuilt from that branch's checkpoint plus the resolved direction, and all
//   younger branches are discarded.
//
// Ports
//   clk          clock, all state updates on posedge
//   reset        asynchronous active-high reset, clears all state
//   PC           low PC bits of the fetch-stage instruction
//   predict      fetch holds a conditional branch this cycle
//   predTaken    predicted direction (1 = taken)
//   index        PHT index = specHistory ^ PC (combinational)
//   tagOut       checkpoint tag given to the fetch branch (= tail)
//   stall        a predict this cycle is not accepted
//   resolve      execute resolved the branch named by resolveTag
//   resolveTag   tag of the resolving branch
//   mispredict   qualifies resolve: the prediction was wrong
//   actualTaken  resolved direction
//   commit       the oldest in-flight branch retires
//   count        number of occupied checkpoints
module ghr_checkpoint_ctrl #(
  parameter int G_WIDTH = 7,
  parameter int DEPTH   = 4,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [G_WIDTH:0]   PC,
  input  logic               predict,
  input  logic               predTaken,
  output logic [G_WIDTH:0]   index,
  output logic [PTR_W-1:0]   tagOut,
  output logic               stall,
  input  logic               resolve,
  input  logic [PTR_W-1:0]   resolveTag,
  input  logic               mispredict,
  input  logic               actualTaken,
  input  logic               commit,
  output logic [PTR_W:0]     count
);

  localparam logic [0:0]     S_NORMAL  = 1'b0;
  localparam logic [0:0]     S_RECOVER = 1'b1;
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);

  logic [G_WIDTH:0] r_hist;
  logic [G_WIDTH:0] r_ckpt [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic [0:0]       r_state;

  logic [PTR_W-1:0] w_off;
  logic             w_tag_valid;
  logic             w_mispred;
  logic             w_accept;
  logic             w_commit;
  logic [G_WIDTH:0] w_restore;
  logic [PTR_W:0]   w_count_nxt;

  // Age of the resolving branch relative to the oldest in-flight one; the
  // subtraction wraps naturally because DEPTH is a power of two.
  assign w_off       = resolveTag - r_head;
  assign w_tag_valid = ((PTR_W+1)'(w_off) < r_count);
  assign w_mispred   = resolve & mispredict & w_tag_valid;

  assign stall    = (r_count == FULL_CNT) | (r_state == S_RECOVER);
  // A valid mispredict wins over a same-cycle predict; fetch will refetch.
  assign w_accept = predict & ~stall & ~w_mispred;
  assign w_commit = commit & (r_count != '0);

  assign w_restore = {r_ckpt[resolveTag][G_WIDTH-1:0], actualTaken};

  assign index  = r_hist ^ PC;
  assign tagOut = r_tail;
  assign count  = r_count;

  always_comb begin
    w_count_nxt = r_count;
    if (w_mispred) begin
      // Survivors are head..t inclusive, minus the one retiring this cycle.
      w_count_nxt = (PTR_W+1)'(w_off) + (PTR_W+1)'(1) - (PTR_W+1)'(w_commit);
    end else begin
      case ({w_accept, w_commit})
        2'b10:   w_count_nxt = r_count + (PTR_W+1)'(1);
        2'b01:   w_count_nxt = r_count - (PTR_W+1)'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= S_NORMAL;
      for (int i = 0; i < DEPTH; i++) r_ckpt[i] <= '0;
    end else begin
      r_count <= w_count_nxt;
      // RECOVER lasts exactly one cycle unless another mispredict arrives.
      r_state <= w_mispred ? S_RECOVER : S_NORMAL;
      if (w_commit) r_head <= r_head + PTR_W'(1);
      if (w_mispred) begin
        r_hist <= w_restore;
        r_tail <= resolveTag + PTR_W'(1);
      end else if (w_accept) begin
        r_ckpt[r_tail] <= r_hist;
        r_hist         <= {r_hist[G_WIDTH-1:0], predTaken};
        r_tail         <= r_tail + PTR_W'(1);
      end
    end
  end

endmodule
